// File: rtl/cpu_pkg.sv
// cpu_pkg: shared server state type and instruction-memory defaults (depth, NOP fill word)
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} imem_state_e;
    localparam int IMEM_DEPTH = 256;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 storage, one write port, one registered read port, no reset
// ports: clk; we_i/waddr_i/wdata_i write; re_i/raddr_i read request; rdata_o holds the last read
module imem_array import cpu_pkg::*; #(
    parameter int DEPTH = IMEM_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_server.sv
// imem_server: boot-loads a little-endian byte stream into instruction memory, then serves 1-cycle fetches
// ports: clk, rst (sync, active-high); req_* fetch request; resp_* fetch response;
//        load_en/load_byte_valid/load_byte boot stream; load_done, load_overflow, busy status
module imem_server import cpu_pkg::*; #(
    parameter int          DEPTH    = IMEM_DEPTH,
    parameter logic [31:0] NOP_WORD = NOP_INSN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    input  logic        load_en,
    input  logic        load_byte_valid,
    input  logic [7:0]  load_byte,
    output logic        load_done,
    output logic        load_overflow,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    imem_state_e state_q, state_d;
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]   byte_cnt_q, byte_cnt_d;
    logic [23:0]  word_q, word_d;
    logic         ovf_q, ovf_d;
    logic         resp_valid_q, fault_q, zero_q;
    logic         we;
    logic [31:0]  wdata, mem_rdata;
    logic         full, rd_en;
    assign full  = wr_ptr_q == (AW+1)'(DEPTH);
    assign rd_en = (state_q == IDLE || state_q == RUN) && !load_en && req_valid;
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        ovf_d       = ovf_q;
        we          = 1'b0;
        wdata       = {8'b0, word_q};
        load_done   = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (load_en) begin
                    state_d    = LOAD;
                    wr_ptr_d   = '0;
                    byte_cnt_d = '0;
                    ovf_d      = 1'b0;
                end else if (req_valid) begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (!load_en) begin
                    state_d = FLUSH;
                end else if (load_byte_valid && full) begin
                    ovf_d = 1'b1;
                end else if (load_byte_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we       = 1'b1;
                        wdata    = {load_byte, word_q};
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else if (byte_cnt_q == 2'd0) begin
                        // lane 0 starts a fresh word so a later partial flush has zero upper lanes
                        word_d = {16'b0, load_byte};
                    end else begin
                        word_d[{byte_cnt_q, 3'b0} +: 8] = load_byte;
                    end
                end
            end
            FLUSH: begin
                busy       = 1'b1;
                load_done  = 1'b1;
                we         = byte_cnt_q != 2'd0;
                byte_cnt_d = '0;
                state_d    = RUN;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            ovf_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            zero_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            ovf_q        <= ovf_d;
            resp_valid_q <= rd_en;
            if (rd_en) begin
                fault_q <= req_addr >= 32'(DEPTH);
                zero_q  <= 1'b0;
            end
        end
    end
    // the array has no reset, so a write landing on a reset edge is suppressed here
    imem_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .we_i    (we && !rst),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wdata),
        .re_i    (rd_en),
        .raddr_i (req_addr[AW-1:0]),
        .rdata_o (mem_rdata)
    );
    // zero_q keeps resp_data at 0 after reset until the first read, since the array read register is not reset
    assign resp_valid    = resp_valid_q;
    assign resp_fault    = resp_valid_q && fault_q;
    assign resp_data     = zero_q ? 32'b0 : fault_q ? NOP_WORD : mem_rdata;
    assign load_overflow = ovf_q;
endmodule

// File: doc/imem_server.md
IMEM_SERVER -- requirements
Module: imem_server

Interface
REQ-001 SHALL have parameter DEPTH, default 256: instruction words held (power of two).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013: word returned on a faulted read.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  fetch presents an address this cycle.
REQ-006 SHALL have port req_addr  input  32  word address, matching the fetch pc, which increments by 1 per instruction.
REQ-007 SHALL have port resp_valid  output  1  resp_data/resp_fault valid this cycle.
REQ-008 SHALL have port resp_data  output  32  instruction word.
REQ-009 SHALL have port resp_fault  output  1  requested address was out of range.
REQ-010 SHALL have port load_en  input  1  boot-load session active while high.
REQ-011 SHALL have port load_byte_valid  input  1  load_byte is valid this cycle.
REQ-012 SHALL have port load_byte  input  8  program byte, little-endian stream.
REQ-013 SHALL have port load_done  output  1  one-cycle pulse when a load session completes.
REQ-014 SHALL have port load_overflow  output  1  sticky flag: bytes were dropped because memory was full.
REQ-015 SHALL have port busy  output  1  high in LOAD and FLUSH.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, FLUSH and RUN.
REQ-017 SHALL transition IDLE->LOAD and RUN->LOAD on load_en=1; on entry to LOAD, SHALL clear the write pointer, the byte counter and load_overflow.
REQ-018 SHALL transition IDLE->RUN on req_valid=1 with load_en=0.
REQ-019 SHALL, in LOAD, shift each accepted byte into word lane byte_cnt (byte 0 -> bits 7:0); on the 4th byte SHALL write the word at wr_ptr, then increment wr_ptr and reset byte_cnt to 0.
REQ-020 SHALL transition LOAD->FLUSH on load_en=0; in FLUSH, if byte_cnt!=0, SHALL write the partial word with unfilled upper lanes zero; SHALL then go FLUSH->RUN and pulse load_done for exactly that one cycle.
REQ-021 SHALL, when wr_ptr==DEPTH (full), drop further bytes, set load_overflow, and leave memory unchanged; wr_ptr SHALL NOT wrap.
REQ-022 SHALL ignore load_byte_valid while load_en=0.
REQ-023 SHALL give reads a latency of 1 cycle: req_valid=1 at edge N -> resp_valid=1 with data after edge N+1, for one cycle per request; back-to-back requests SHALL give back-to-back responses.
REQ-024 SHALL service reads only in IDLE and RUN; in LOAD and FLUSH, req_valid SHALL be ignored and resp_valid SHALL be 0.
REQ-025 SHALL give precedence to load_en when load_en and req_valid are both 1 in IDLE or RUN: no response is generated.
REQ-026 SHALL treat req_addr>=DEPTH as a fault: resp_data=NOP_WORD and resp_fault=1; otherwise resp_fault=0.
REQ-027 SHALL hold resp_data at its last value while resp_valid=0.

Reset
REQ-028 SHALL, on rst=1 at an edge, set state=IDLE, wr_ptr=0, byte_cnt=0, resp_valid=0, resp_data=0, resp_fault=0, load_done=0, load_overflow=0 and busy=0.
REQ-029 SHALL NOT clear memory contents on rst; reset in the middle of a load SHALL discard the partially assembled word and keep words already written.

Structure
REQ-030 SHALL take the state enum, NOP_WORD default and DEPTH default from the shared cpu package.
REQ-031 SHALL place storage in one sub-module, imem_array: single write port and single registered read port, no reset.

Verification
REQ-032 SHALL be covered by this scenario: load bytes 13,00,00,00,93,00,10,00 then drop load_en -> load_done pulses once; reads of addr 0 and 1 return 32'h00000013 and 32'h00100093 one cycle later.
REQ-033 SHALL be covered by this scenario: load 5 bytes AA,BB,CC,DD,EE -> addr 1 reads 32'h000000EE.
REQ-034 SHALL be covered by this scenario: req_addr=DEPTH -> next cycle resp_valid=1, resp_fault=1, resp_data=32'h00000013.
REQ-035 SHALL be covered by this scenario: load 4*DEPTH+4 bytes -> load_overflow=1 and addr 0 is unchanged by the extra word.
REQ-036 SHALL be covered by this scenario: req_valid and load_en asserted in the same RUN cycle -> no resp_valid and busy=1 on the next cycle.
REQ-037 SHALL be covered by this scenario: rst after 6 bytes -> IDLE, word 0 retained, word 1 not written, all outputs 0.
